ide_disk_sched: RTL and testbench
=================================

Name: ide_disk_sched

Overview:
- Arbiter and sequencer in front of the single-block IDE disk engine (`ide_disk`).
- Two requesters share the engine, e.g. a fixed-head disk emulation and a DECtape emulation. Each posts a multi-block transfer: start LBA, block count, read/write.
- The block grants one requester at a time, round-robin. It issues one `ide_disk` request per 256-word block, advances the LBA, accumulates errors and guards each block with a watchdog.
- It also publishes the current owner so the 256x12 sector buffer port can be muxed outside this block.

Parameters:
- TMO_W, 20, width of the per-block watchdog counter; timeout after 2^TMO_W-1 cycles.
- LBA_W, 25, width of all LBA ports.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- r0_req  in  1  requester 0 transfer request (level)
- r0_wr  in  1  requester 0 direction: 1 = write to disk, 0 = read
- r0_lba  in  LBA_W  requester 0 start LBA
- r0_nblk  in  8  requester 0 block count; 0 means 256
- r0_ack  out  1  one-cycle completion pulse to requester 0
- r0_blk  out  1  one-cycle pulse per block completed for requester 0
- r1_req, r1_wr, r1_lba, r1_nblk, r1_ack, r1_blk  same as requester 0, for requester 1
- xfer_err  out  1  error status of the last finished transfer; valid while either ack is high
- owner  out  1  current grant (0/1); valid while busy
- busy  out  1  a transfer is in progress
- ide_lba  out  LBA_W  LBA to `ide_disk`
- ide_read_req  out  1  read request to `ide_disk` (level)
- ide_write_req  out  1  write request to `ide_disk` (level)
- ide_done  in  1  `ide_disk` done; high while idle, drops when an operation starts, rises when it completes
- ide_error  in  1  `ide_disk` error flag; sampled when ide_done rises

Behaviour:
- All outputs are registered. Reset values: all acks, blk pulses, reqs, busy and xfer_err are 0; owner = 0; ide_lba = 0; rr_last = 1, so requester 0 wins first.
- Reset is honoured in any state, including mid-transfer: requests drop the next cycle. No ack is issued for an aborted transfer.
- States: IDLE, ISSUE, WAIT_DONE, GAP, DRAIN, FINISH.
- IDLE:
  - Sample r0_req and r1_req. If both are high, grant the one that is not rr_last. If only one is high, grant it.
  - On grant: latch wr, lba and nblk into cur_* (nblk 0 is loaded as 256 in a 9-bit remaining counter); set owner, busy = 1, err_acc = 0, rr_last = grantee; go to ISSUE.
- ISSUE:
  - ide_lba = cur_lba; assert ide_write_req if cur_wr, otherwise ide_read_req. Load the watchdog.
  - Stay until ide_done == 0, then go to WAIT_DONE.
- WAIT_DONE:
  - Hold the request. Stay until ide_done == 1.
  - When ide_done == 1: err_acc |= ide_error; pulse rN_blk for the owner; drop the request.
  - If remaining == 1 or err_acc would be set: go to FINISH.
  - Otherwise: remaining -= 1; cur_lba += 1, wrapping modulo 2^LBA_W; go to GAP.
- GAP:
  - Exactly one cycle with both ide requests low, so `ide_disk` passes through its ready state without restarting. Then go to ISSUE.
- Watchdog:
  - Decrements in ISSUE and WAIT_DONE. At 0: set err_acc, drop the request, go to DRAIN.
  - DRAIN waits for ide_done == 1, then goes to FINISH.
- FINISH:
  - One cycle: rN_ack = 1 for the owner; xfer_err = err_acc; busy = 0 at exit; go to IDLE.
- Requester rules:
  - A requester must deassert rN_req on the clock edge where it samples rN_ack = 1.
  - rN_req and its inputs are only sampled in IDLE. Changes during a transfer are ignored; the transfer runs to completion.
- An error ends the transfer after the failing block. No further blocks are issued.
- ide_read_req and ide_write_req are never high together.
- Both request lines are low in IDLE, GAP, DRAIN and FINISH.

Decomposition:
- Package ide_sched_pkg: state encoding (3-bit localparams), OWNER_R0 = 0 / OWNER_R1 = 1, default TMO_W.
- Sub-module rr_arb2:
  - Inputs: clk, reset, req[1:0], advance.
  - Outputs: gnt[1:0] (one-hot or zero), gnt_id.
  - Holds rr_last internally.

Test Plan:
- Single read: r0 requests lba = 0x100, nblk = 3, wr = 0; `ide_disk` model completes each block → ide_read_req issued 3 times at lba 0x100, 0x101 and 0x102; 3 r0_blk pulses; one r0_ack with xfer_err = 0; exactly one low GAP cycle between blocks.
- Contention: r0 and r1 both request in the same cycle after reset → r0 served first, then r1. Immediately re-raise both → r1 is not served twice in a row; order is r0, r1, r0.
- Error: r1 write, nblk = 4; model sets ide_error on block 2 → ide_write_req only at lba and lba+1; r1_ack with xfer_err = 1; no third issue.
- nblk = 0 at lba = 0x1FFFFFF → 256 blocks issued; LBA wraps to 0 after the first block; ack after the 256th r1_blk.
- Watchdog with TMO_W = 4: model never drops ide_done → request dropped after 15 cycles in ISSUE; after ide_done is seen high, ack with xfer_err = 1.
- Reset asserted mid WAIT_DONE → next cycle all requests low, busy = 0, no ack; a fresh request after reset is served normally.

Source files
------------

// File: rtl/ide_sched_pkg.sv
// rtl/ide_sched_pkg.sv - shared types and constants for the IDE disk scheduler
package ide_sched_pkg;

   localparam int TMO_W_DEF = 20;
   localparam int LBA_W_DEF = 25;

   localparam logic OWNER_R0 = 1'b0;
   localparam logic OWNER_R1 = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_GAP       = 3'd3,
      ST_DRAIN     = 3'd4,
      ST_FINISH    = 3'd5
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter holding the last grantee
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   // rr_last_q starts at 1 so requester 0 wins the first contention
   logic rr_last_q;

   // pick the requester that did not win last time when both ask
   always_comb begin
      gnt_id = 1'b0;
      if (req == 2'b11) begin
         gnt_id = ~rr_last_q;
      end else if (req == 2'b10) begin
         gnt_id = 1'b1;
      end
      gnt = 2'b00;
      if (req != 2'b00) begin
         gnt = gnt_id ? 2'b10 : 2'b01;
      end
   end

   // remember the grantee whenever a grant is actually taken
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_last_q <= 1'b1;
      end else if (advance && (req != 2'b00)) begin
         rr_last_q <= gnt_id;
      end
   end

endmodule

// File: rtl/ide_disk_sched.sv
// rtl/ide_disk_sched.sv - arbitrates two multi-block requesters onto one IDE block engine
module ide_disk_sched
   import ide_sched_pkg::*;
#(
   parameter int TMO_W = TMO_W_DEF,
   parameter int LBA_W = LBA_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             r0_req,
   input  logic             r0_wr,
   input  logic [LBA_W-1:0] r0_lba,
   input  logic [7:0]       r0_nblk,
   output logic             r0_ack,
   output logic             r0_blk,
   input  logic             r1_req,
   input  logic             r1_wr,
   input  logic [LBA_W-1:0] r1_lba,
   input  logic [7:0]       r1_nblk,
   output logic             r1_ack,
   output logic             r1_blk,
   output logic             xfer_err,
   output logic             owner,
   output logic             busy,
   output logic [LBA_W-1:0] ide_lba,
   output logic             ide_read_req,
   output logic             ide_write_req,
   input  logic             ide_done,
   input  logic             ide_error
);

   state_t             state_q;
   logic               cur_wr_q;
   logic [LBA_W-1:0]   cur_lba_q;
   logic [8:0]         remaining_q;
   logic               err_acc_q;
   logic [TMO_W-1:0]   wdog_q;
   logic               owner_q;
   logic               busy_q;
   logic               rd_q;
   logic               wr_q;
   logic               r0_ack_q;
   logic               r1_ack_q;
   logic               r0_blk_q;
   logic               r1_blk_q;
   logic               xfer_err_q;
   logic [LBA_W-1:0]   ide_lba_q;

   logic [1:0]         arb_gnt;
   logic               arb_id;
   logic               sel_wr;
   logic [LBA_W-1:0]   sel_lba;
   logic [7:0]         sel_nblk;
   logic               err_d;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({r1_req, r0_req}),
      .advance (state_q == ST_IDLE),
      .gnt     (arb_gnt),
      .gnt_id  (arb_id)
   );

   // route the granted requester's transfer parameters
   always_comb begin
      sel_wr   = arb_id ? r1_wr   : r0_wr;
      sel_lba  = arb_id ? r1_lba  : r0_lba;
      sel_nblk = arb_id ? r1_nblk : r0_nblk;
      err_d    = err_acc_q | ide_error;
   end

   // transfer sequencer; every output is a register updated here
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cur_wr_q    <= 1'b0;
         cur_lba_q   <= '0;
         remaining_q <= '0;
         err_acc_q   <= 1'b0;
         wdog_q      <= '0;
         owner_q     <= OWNER_R0;
         busy_q      <= 1'b0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         r0_ack_q    <= 1'b0;
         r1_ack_q    <= 1'b0;
         r0_blk_q    <= 1'b0;
         r1_blk_q    <= 1'b0;
         xfer_err_q  <= 1'b0;
         ide_lba_q   <= '0;
      end else begin
         r0_ack_q <= 1'b0;
         r1_ack_q <= 1'b0;
         r0_blk_q <= 1'b0;
         r1_blk_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (arb_gnt != 2'b00) begin
                  owner_q     <= arb_id;
                  busy_q      <= 1'b1;
                  err_acc_q   <= 1'b0;
                  cur_wr_q    <= sel_wr;
                  cur_lba_q   <= sel_lba;
                  // a block count of 0 means a full 256-block transfer
                  remaining_q <= {sel_nblk == 8'd0, sel_nblk};
                  ide_lba_q   <= sel_lba;
                  rd_q        <= ~sel_wr;
                  wr_q        <= sel_wr;
                  wdog_q      <= '1;
                  state_q     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (wdog_q == TMO_W'(1)) begin
                  err_acc_q <= 1'b1;
                  rd_q      <= 1'b0;
                  wr_q      <= 1'b0;
                  state_q   <= ST_DRAIN;
               end else begin
                  wdog_q <= wdog_q - TMO_W'(1);
                  if (!ide_done) begin
                     state_q <= ST_WAIT_DONE;
                  end
               end
            end
            ST_WAIT_DONE: begin
               // a completion wins over a watchdog expiring in the same cycle
               if (ide_done) begin
                  err_acc_q <= err_d;
                  r0_blk_q  <= (owner_q == OWNER_R0);
                  r1_blk_q  <= (owner_q == OWNER_R1);
                  rd_q      <= 1'b0;
                  wr_q      <= 1'b0;
                  if ((remaining_q == 9'd1) || err_d) begin
                     r0_ack_q   <= (owner_q == OWNER_R0);
                     r1_ack_q   <= (owner_q == OWNER_R1);
                     xfer_err_q <= err_d;
                     state_q    <= ST_FINISH;
                  end else begin
                     remaining_q <= remaining_q - 9'd1;
                     cur_lba_q   <= cur_lba_q + LBA_W'(1);
                     state_q     <= ST_GAP;
                  end
               end else if (wdog_q == TMO_W'(1)) begin
                  err_acc_q <= 1'b1;
                  rd_q      <= 1'b0;
                  wr_q      <= 1'b0;
                  state_q   <= ST_DRAIN;
               end else begin
                  wdog_q <= wdog_q - TMO_W'(1);
               end
            end
            ST_GAP: begin
               // one idle cycle lets the engine return to ready before the next block
               ide_lba_q <= cur_lba_q;
               rd_q      <= ~cur_wr_q;
               wr_q      <= cur_wr_q;
               wdog_q    <= '1;
               state_q   <= ST_ISSUE;
            end
            ST_DRAIN: begin
               if (ide_done) begin
                  r0_ack_q   <= (owner_q == OWNER_R0);
                  r1_ack_q   <= (owner_q == OWNER_R1);
                  xfer_err_q <= err_acc_q;
                  state_q    <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign r0_ack        = r0_ack_q;
   assign r1_ack        = r1_ack_q;
   assign r0_blk        = r0_blk_q;
   assign r1_blk        = r1_blk_q;
   assign xfer_err      = xfer_err_q;
   assign owner         = owner_q;
   assign busy          = busy_q;
   assign ide_lba       = ide_lba_q;
   assign ide_read_req  = rd_q;
   assign ide_write_req = wr_q;

endmodule

// File: tb/tb_ide_disk_sched.sv
// tb/tb_ide_disk_sched.sv - scoreboard bench for ide_disk_sched
module tb_ide_disk_sched;

   localparam int LW = 25;

   typedef struct {
      logic [LW-1:0] lba;
      logic          wr;
      logic          first;
   } issue_t;

   typedef struct {
      logic id;
      logic err;
      int   nblk;
   } ack_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic          r0_req = 0, r0_wr = 0, r1_req = 0, r1_wr = 0;
   logic [LW-1:0] r0_lba = '0, r1_lba = '0;
   logic [7:0]    r0_nblk = 8'd1, r1_nblk = 8'd1;
   logic          r0_ack, r0_blk, r1_ack, r1_blk, xfer_err, owner, busy;
   logic [LW-1:0] ide_lba;
   logic          ide_read_req, ide_write_req;
   logic          ide_done = 1'b1, ide_error = 1'b0;

   logic          w_req = 0;
   logic [LW-1:0] w_lba = 25'd7;
   logic          w_r0_ack, w_r0_blk, w_r1_ack, w_r1_blk, w_err, w_owner, w_busy;
   logic [LW-1:0] w_ide_lba;
   logic          w_rd, w_wr;

   ide_disk_sched #(.TMO_W(20), .LBA_W(LW)) u_dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_wr(r0_wr), .r0_lba(r0_lba), .r0_nblk(r0_nblk),
      .r0_ack(r0_ack), .r0_blk(r0_blk),
      .r1_req(r1_req), .r1_wr(r1_wr), .r1_lba(r1_lba), .r1_nblk(r1_nblk),
      .r1_ack(r1_ack), .r1_blk(r1_blk),
      .xfer_err(xfer_err), .owner(owner), .busy(busy), .ide_lba(ide_lba),
      .ide_read_req(ide_read_req), .ide_write_req(ide_write_req),
      .ide_done(ide_done), .ide_error(ide_error)
   );

   ide_disk_sched #(.TMO_W(4), .LBA_W(LW)) u_wd (
      .clk(clk), .reset(reset),
      .r0_req(w_req), .r0_wr(1'b0), .r0_lba(w_lba), .r0_nblk(8'd1),
      .r0_ack(w_r0_ack), .r0_blk(w_r0_blk),
      .r1_req(1'b0), .r1_wr(1'b0), .r1_lba('0), .r1_nblk(8'd1),
      .r1_ack(w_r1_ack), .r1_blk(w_r1_blk),
      .xfer_err(w_err), .owner(w_owner), .busy(w_busy), .ide_lba(w_ide_lba),
      .ide_read_req(w_rd), .ide_write_req(w_wr),
      .ide_done(1'b1), .ide_error(1'b0)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   issue_t exp_issue[$];
   ack_t   exp_ack[$];

   task automatic push_issue(input logic [LW-1:0] lba, input logic wr, input logic first);
      issue_t e;
      e.lba = lba; e.wr = wr; e.first = first;
      exp_issue.push_back(e);
   endtask

   task automatic push_ack(input logic id, input logic err, input int nblk);
      ack_t a;
      a.id = id; a.err = err; a.nblk = nblk;
      exp_ack.push_back(a);
   endtask

   // engine model state
   logic          m_busy = 0, m_need_low = 0, m_err_pend = 0;
   int            m_cnt = 0, m_low = 0, n_issue = 0;
   logic          fail_en = 0;
   logic [LW-1:0] fail_lba = '0;
   int            blk0 = 0, blk1 = 0;

   // ide_disk model plus issue/ack scoreboard, sampled 1ns after each edge
   always begin
      @(posedge clk); #1;
      if (reset) begin
         ide_done = 1'b1; ide_error = 1'b0;
         m_busy = 0; m_need_low = 0; m_low = 0;
         blk0 = 0; blk1 = 0;
      end else begin
         if (m_busy) begin
            if (m_cnt == 0) begin
               ide_done = 1'b1; ide_error = m_err_pend;
               m_busy = 0; m_need_low = 1; m_low = 0;
            end else begin
               m_cnt--;
            end
         end else if (!(ide_read_req || ide_write_req)) begin
            m_need_low = 0;
            m_low++;
         end else if (!m_need_low) begin
            issue_t e;
            chk("rw_excl", {31'd0, ide_read_req & ide_write_req}, 32'd0);
            chk("issue_pending", {31'd0, exp_issue.size() != 0}, 32'd1);
            if (exp_issue.size() != 0) begin
               e = exp_issue.pop_front();
               chk("issue_lba", {7'd0, ide_lba}, {7'd0, e.lba});
               chk("issue_wr", {31'd0, ide_write_req}, {31'd0, e.wr});
               if (!e.first) chk("gap_cycles", m_low, 32'd1);
            end
            m_err_pend = fail_en && (ide_lba == fail_lba);
            ide_done = 1'b0; ide_error = 1'b0;
            m_busy = 1; m_cnt = 2 + int'($urandom_range(0, 2));
            n_issue++;
         end
         if (r0_blk) blk0++;
         if (r1_blk) blk1++;
         if (r0_ack || r1_ack) begin
            ack_t a;
            chk("ack_pending", {31'd0, exp_ack.size() != 0}, 32'd1);
            chk("ack_onehot", {31'd0, r0_ack & r1_ack}, 32'd0);
            if (exp_ack.size() != 0) begin
               a = exp_ack.pop_front();
               chk("ack_id", {31'd0, r1_ack}, {31'd0, a.id});
               chk("ack_owner", {31'd0, owner}, {31'd0, a.id});
               chk("ack_err", {31'd0, xfer_err}, {31'd0, a.err});
               chk("ack_blks", a.id ? blk1 : blk0, a.nblk);
            end
            if (r0_ack) blk0 = 0;
            if (r1_ack) blk1 = 0;
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_ack(input logic id, input int budget);
      int n = 0;
      while (n < budget) begin
         @(posedge clk); #1;
         if ((!id && r0_ack) || (id && r1_ack)) break;
         n++;
      end
      chk(id ? "ack1_seen" : "ack0_seen", {31'd0, n < budget}, 32'd1);
      if (id) r1_req = 1'b0; else r0_req = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int wcnt, n;
      logic [LW-1:0] l;

      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_owner", {31'd0, owner}, 32'd0);
      chk("rst_lba", {7'd0, ide_lba}, 32'd0);
      chk("rst_reqs", {30'd0, ide_read_req, ide_write_req}, 32'd0);
      chk("rst_acks", {28'd0, r0_ack, r1_ack, r0_blk, r1_blk}, 32'd0);
      chk("rst_err", {31'd0, xfer_err}, 32'd0);

      // contention: r0 first, then alternate
      push_issue(25'h10, 0, 1); push_issue(25'h20, 0, 1);
      push_issue(25'h30, 0, 1); push_issue(25'h50, 0, 1);
      push_ack(0, 0, 1); push_ack(1, 0, 1); push_ack(0, 0, 1); push_ack(1, 0, 1);
      r0_lba = 25'h10; r0_nblk = 8'd1; r0_wr = 0;
      r1_lba = 25'h20; r1_nblk = 8'd1; r1_wr = 0;
      r0_req = 1; r1_req = 1;
      wait_ack(0, 100);
      tick(1); r0_lba = 25'h30; r0_req = 1;
      wait_ack(1, 100);
      tick(1); r1_lba = 25'h50; r1_req = 1;
      wait_ack(0, 100);
      wait_ack(1, 100);
      tick(3);
      chk("cont_q_empty", exp_issue.size(), 32'd0);

      // single three-block read
      push_issue(25'h100, 0, 1); push_issue(25'h101, 0, 0); push_issue(25'h102, 0, 0);
      push_ack(0, 0, 3);
      r0_lba = 25'h100; r0_nblk = 8'd3; r0_wr = 0; r0_req = 1;
      wait_ack(0, 200);
      tick(3);
      chk("rd_q_empty", exp_issue.size(), 32'd0);

      // write with error on the second block
      fail_en = 1; fail_lba = 25'h301;
      push_issue(25'h300, 1, 1); push_issue(25'h301, 1, 0);
      push_ack(1, 1, 2);
      r1_lba = 25'h300; r1_nblk = 8'd4; r1_wr = 1; r1_req = 1;
      n = n_issue;
      wait_ack(1, 200);
      tick(10);
      chk("err_issues", n_issue - n, 32'd2);
      fail_en = 0;

      // 256 blocks with LBA wrap
      l = 25'h1FFFFFF;
      for (int i = 0; i < 256; i++) begin
         push_issue(l, 0, i == 0);
         l = l + 25'd1;
      end
      push_ack(1, 0, 256);
      r1_lba = 25'h1FFFFFF; r1_nblk = 8'd0; r1_wr = 0; r1_req = 1;
      wait_ack(1, 5000);
      tick(3);
      chk("wrap_q_empty", exp_issue.size(), 32'd0);

      // watchdog on the short-timeout instance
      wcnt = 0; n = 0;
      w_req = 1;
      while (n < 100) begin
         @(posedge clk); #1;
         if (w_rd) wcnt++;
         chk("wd_no_write", {31'd0, w_wr}, 32'd0);
         if (w_r0_ack) break;
         n++;
      end
      w_req = 0;
      chk("wd_ack_seen", {31'd0, n < 100}, 32'd1);
      chk("wd_req_cycles", wcnt, 32'd15);
      chk("wd_xfer_err", {31'd0, w_err}, 32'd1);
      chk("wd_blk", {30'd0, w_r0_blk, w_r1_ack}, 32'd0);

      // reset in the middle of a transfer
      push_issue(25'h40, 0, 1);
      r0_lba = 25'h40; r0_nblk = 8'd5; r0_wr = 0; r0_req = 1;
      n = 0; wcnt = n_issue;
      while ((n_issue == wcnt) && (n < 50)) begin
         tick(1); n++;
      end
      chk("mid_started", {31'd0, n < 50}, 32'd1);
      tick(1);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1; r0_req = 0;
      tick(1);
      chk("mid_rst_reqs", {30'd0, ide_read_req, ide_write_req}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      tick(1);
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("mid_no_ack", {30'd0, r0_ack, r1_ack}, 32'd0);
      end
      exp_issue.delete();

      // fresh transfer after reset
      push_issue(25'h200, 0, 1); push_issue(25'h201, 0, 0);
      push_ack(0, 0, 2);
      r0_lba = 25'h200; r0_nblk = 8'd2; r0_req = 1;
      wait_ack(0, 200);
      tick(3);
      chk("fresh_q_empty", exp_issue.size() + exp_ack.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
